// File: rtl/led_seq_sched_pkg.sv
// LED sequence scheduler: shared types and default sizes.
package led_seq_sched_pkg;

  localparam int NUM_SLOTS_DEF = 8;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_EXPOSE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  // One slot-table entry: which LED fires, when, and for how long.
  // dly is the number of cycles from the trigger edge to LED on.
  // exp is the exposure length minus one, in cycles.
  typedef struct packed {
    logic [2:0]           led;
    logic [CNT_W_DEF-1:0] dly;
    logic [CNT_W_DEF-1:0] exp;
  } slot_t;

endpackage

// File: rtl/led_seq_sched_table.sv
// Slot table for the LED scheduler: NUM_SLOTS entries, one synchronous write
// port, one combinational read port. Reset clears every entry.
module led_slot_table
  import led_seq_sched_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  slot_t      wdata,
  input  logic [2:0] raddr,
  output slot_t      rdata
);

  slot_t mem_q [NUM_SLOTS];
  slot_t mem_d [NUM_SLOTS];

  // Next table contents: the addressed entry is replaced when we is high.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Table storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/led_seq_sched.sv
// LED sequence scheduler. Steps through a table of LED slots, one slot per
// projector trigger edge, firing each LED after a programmed delay for a
// programmed exposure. Runs frame_num sequences, or forever when it is 0.
// Optional build macro LED_SEQ_SCHED_OVERRUN_EN adds sticky detection of a
// trigger edge arriving while a slot is still in its delay or exposure.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not running; table writable, waiting for start
// ARMED  | waiting for a projector trigger edge for the current slot
// DELAY  | counting down the slot delay
// EXPOSE | current slot LED driven low for exp+1 cycles
// HOLD   | LED off; waiting for proj_trg to drop, then advance slot
module led_seq_sched
  import led_seq_sched_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [2:0]       cfg_led,
  input  logic [CNT_W-1:0] cfg_dly,
  input  logic [CNT_W-1:0] cfg_exp,
  input  logic [3:0]       seq_len,
  input  logic [31:0]      frame_num,
  input  logic             start,
  input  logic             stop,
  input  logic             proj_trg,
  output logic [7:0]       trig,
  output logic             busy,
  output logic [2:0]       slot_idx,
  output logic [31:0]      frame_cnt,
  output logic             done,
  output logic             err_overrun
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       slot_idx_q, slot_idx_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             trg_dly_q, trg_dly_d;
`ifdef LED_SEQ_SCHED_OVERRUN_EN
  logic             err_q, err_d;
`endif

  logic       trg_edge;
  logic [2:0] last_slot;
  logic [31:0] frame_nxt;
  logic       tbl_we;
  slot_t      wr_slot;
  slot_t      cur_slot;

  assign trg_edge  = proj_trg & ~trg_dly_q;
  assign frame_nxt = frame_cnt_q + 32'd1;
  // The table is frozen while a run is in progress.
  assign tbl_we    = cfg_we && (state_q == ST_IDLE);

  assign wr_slot.led = cfg_led;
  assign wr_slot.dly = cfg_dly;
  assign wr_slot.exp = cfg_exp;

  led_slot_table #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (wr_slot),
    .raddr (slot_idx_q),
    .rdata (cur_slot)
  );

  // Last active slot index; out-of-range lengths run the full table.
  always_comb begin
    last_slot = 3'd7;
    if (seq_len != 4'd0 && seq_len <= 4'd8) last_slot = 3'(seq_len - 4'd1);
  end

  // Next-state, counter and output decode for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_idx_d  = slot_idx_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    trg_dly_d   = proj_trg;
`ifdef LED_SEQ_SCHED_OVERRUN_EN
    err_d       = err_q;
`endif

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_ARMED;
            slot_idx_d  = 3'd0;
            frame_cnt_d = 32'd0;
`ifdef LED_SEQ_SCHED_OVERRUN_EN
            err_d       = 1'b0;
`endif
          end
        end
        ST_ARMED: begin
          if (trg_edge) begin
            state_d = ST_DELAY;
            cnt_d   = cur_slot.dly;
          end
        end
        ST_DELAY: begin
          if (cnt_q == '0) begin
            state_d = ST_EXPOSE;
            cnt_d   = cur_slot.exp;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_EXPOSE: begin
          if (cnt_q == '0) state_d = ST_HOLD;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_HOLD: begin
          if (!proj_trg) begin
            if (slot_idx_q == last_slot) begin
              slot_idx_d  = 3'd0;
              frame_cnt_d = frame_nxt;
              if (frame_num != 32'd0 && frame_nxt == frame_num) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_ARMED;
              end
            end else begin
              slot_idx_d = slot_idx_q + 3'd1;
              state_d    = ST_ARMED;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
`ifdef LED_SEQ_SCHED_OVERRUN_EN
      // A new edge before the slot finished means the trigger outran us.
      if ((state_q == ST_DELAY || state_q == ST_EXPOSE) && trg_edge) err_d = 1'b1;
`endif
    end

    // Outputs are decoded from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    trig_d = 8'hFF;
    if (state_d == ST_EXPOSE) trig_d = ~(8'h01 << cur_slot.led);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      slot_idx_q  <= 3'd0;
      frame_cnt_q <= 32'd0;
      trig_q      <= 8'hFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trg_dly_q   <= 1'b0;
`ifdef LED_SEQ_SCHED_OVERRUN_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_idx_q  <= slot_idx_d;
      frame_cnt_q <= frame_cnt_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trg_dly_q   <= trg_dly_d;
`ifdef LED_SEQ_SCHED_OVERRUN_EN
      err_q       <= err_d;
`endif
    end
  end

  assign trig      = trig_q;
  assign busy      = busy_q;
  assign slot_idx  = slot_idx_q;
  assign frame_cnt = frame_cnt_q;
  assign done      = done_q;
`ifdef LED_SEQ_SCHED_OVERRUN_EN
  assign err_overrun = err_q;
`else
  assign err_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_led_seq_sched.sv
// Directed bench for led_seq_sched. Honours LED_SEQ_SCHED_OVERRUN_EN when
// choosing the expected err_overrun behaviour.
module tb_led_seq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [2:0]  cfg_led;
  logic [15:0] cfg_dly;
  logic [15:0] cfg_exp;
  logic [3:0]  seq_len;
  logic [31:0] frame_num;
  logic        start;
  logic        stop;
  logic        proj_trg;
  logic [7:0]  trig;
  logic        busy;
  logic [2:0]  slot_idx;
  logic [31:0] frame_cnt;
  logic        done;
  logic        err_overrun;

  int total = 0;
  int bad   = 0;

`ifdef LED_SEQ_SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  led_seq_sched dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_led     (cfg_led),
    .cfg_dly     (cfg_dly),
    .cfg_exp     (cfg_exp),
    .seq_len     (seq_len),
    .frame_num   (frame_num),
    .start       (start),
    .stop        (stop),
    .proj_trg    (proj_trg),
    .trig        (trig),
    .busy        (busy),
    .slot_idx    (slot_idx),
    .frame_cnt   (frame_cnt),
    .done        (done),
    .err_overrun (err_overrun)
  );

  // Outputs are sampled and inputs driven 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int led, input int d, input int e);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_led = 3'(led);
    cfg_dly = 16'(d); cfg_exp = 16'(e);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Raise proj_trg for one cycle, then watch trig, done and busy through
  // delay, exposure and hold until the slot has advanced. An optional second
  // trigger pulse is raised after tick glitch_at.
  task automatic fire(input int d, input int e, input int led, input bit last,
                      input int glitch_at, input string name);
    logic [7:0] one8;
    logic [7:0] exp_t;
    logic       exp_done;
    int         n_end;
    one8  = 8'h01;
    n_end = 4 + d + e;
    proj_trg = 1'b1;
    for (int n = 1; n <= n_end; n++) begin
      tick();
      exp_t = (n >= 2 + d && n <= 2 + d + e) ? ~(one8 << led) : 8'hFF;
      total++;
      if (trig !== exp_t) begin
        bad++;
        $display("FAIL %s trig n=%0d got=%h want=%h", name, n, trig, exp_t);
      end
      exp_done = last && (n == n_end);
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL %s done n=%0d got=%b want=%b", name, n, done, exp_done);
      end
      if (n == n_end) begin
        total++;
        if (busy !== !last) begin
          bad++;
          $display("FAIL %s busy_end got=%b want=%b", name, busy, !last);
        end
      end
      if (n == 1) proj_trg = 1'b0;
      if (glitch_at != 0 && n == glitch_at) proj_trg = 1'b1;
      if (glitch_at != 0 && n == glitch_at + 1) proj_trg = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (trig !== 8'hFF || busy !== 1'b0 || slot_idx !== 3'd0 || frame_cnt !== 32'd0 ||
        done !== 1'b0 || err_overrun !== 1'b0) begin
      bad++;
      $display("FAIL %s got trig=%h busy=%b slot=%0d fc=%0d done=%b err=%b want FF/0/0/0/0/0",
               name, trig, busy, slot_idx, frame_cnt, done, err_overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_single();
    wr(0, 2, 3, 4);
    seq_len = 4'd1; frame_num = 32'd1;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL single busy_after_start got=%b want=1", busy);
    end
    fire(3, 4, 2, 1'b1, 0, "single");
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || frame_cnt !== 32'd1) begin
      bad++;
      $display("FAIL single end got done=%b busy=%b fc=%0d want 0/0/1", done, busy, frame_cnt);
    end
  endtask

  task automatic test_multi();
    int leds[3] = '{0, 5, 7};
    int dlys[3] = '{1, 0, 2};
    int exps[3] = '{2, 1, 0};
    for (int s = 0; s < 3; s++) wr(s, leds[s], dlys[s], exps[s]);
    seq_len = 4'd3; frame_num = 32'd2;
    pulse_start();
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 3; s++) begin
        total++;
        if (slot_idx !== 3'(s)) begin
          bad++; $display("FAIL multi slot_idx got=%0d want=%0d", slot_idx, s);
        end
        fire(dlys[s], exps[s], leds[s], (f == 1 && s == 2), 0, "multi");
        if (f == 0 && s == 0) begin
          pulse_start();
          total++;
          if (slot_idx !== 3'd1) begin
            bad++; $display("FAIL multi start_while_busy slot got=%0d want=1", slot_idx);
          end
        end
      end
      total++;
      if (frame_cnt !== 32'(f + 1)) begin
        bad++; $display("FAIL multi frame_cnt got=%0d want=%0d", frame_cnt, f + 1);
      end
    end
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL multi end got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_zero_timing();
    wr(0, 4, 0, 0);
    seq_len = 4'd1; frame_num = 32'd1;
    pulse_start();
    fire(0, 0, 4, 1'b1, 0, "zero");
  endtask

  task automatic test_stop();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL start_stop_same busy got=%b want=0", busy);
    end
    wr(0, 1, 1, 5);
    seq_len = 4'd1; frame_num = 32'd0;
    pulse_start();
    proj_trg = 1'b1;
    tick();
    proj_trg = 1'b0;
    for (int n = 2; n <= 4; n++) tick();
    total++;
    if (trig !== 8'hFD) begin
      bad++; $display("FAIL stop expose_on got=%h want=FD", trig);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (trig !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || frame_cnt !== 32'd0) begin
      bad++;
      $display("FAIL stop after got trig=%h busy=%b done=%b fc=%0d want FF/0/0/0",
               trig, busy, done, frame_cnt);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (done !== 1'b0 || trig !== 8'hFF) begin
        bad++; $display("FAIL stop quiet got done=%b trig=%h want 0/FF", done, trig);
      end
    end
    pulse_start();
    total++;
    if (slot_idx !== 3'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL stop restart got slot=%0d busy=%b want 0/1", slot_idx, busy);
    end
    fire(1, 5, 1, 1'b0, 0, "stop_rerun");
    total++;
    if (frame_cnt !== 32'd1) begin
      bad++; $display("FAIL stop continuous fc got=%0d want=1", frame_cnt);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_overrun();
    wr(0, 3, 4, 1);
    seq_len = 4'd1; frame_num = 32'd1;
    pulse_start();
    fire(4, 1, 3, 1'b1, 2, "overrun");
    total++;
    if (err_overrun !== OVR_EN) begin
      bad++; $display("FAIL overrun flag got=%b want=%b", err_overrun, OVR_EN);
    end
    tick();
    total++;
    if (err_overrun !== OVR_EN) begin
      bad++; $display("FAIL overrun sticky got=%b want=%b", err_overrun, OVR_EN);
    end
    pulse_start();
    total++;
    if (err_overrun !== 1'b0) begin
      bad++; $display("FAIL overrun clear_on_start got=%b want=0", err_overrun);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_busy_cfg_and_rst();
    wr(0, 6, 1, 1);
    seq_len = 4'd1; frame_num = 32'd1;
    pulse_start();
    wr(0, 0, 0, 0);
    fire(1, 1, 6, 1'b1, 0, "cfg_busy");
    pulse_start();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rst_armed pre busy got=%b want=1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_armed");
    pulse_start();
    fire(0, 0, 0, 1'b1, 0, "table_cleared");
  endtask

  task automatic test_rst_expose();
    wr(0, 5, 0, 6);
    seq_len = 4'd1; frame_num = 32'd1;
    pulse_start();
    proj_trg = 1'b1;
    tick();
    proj_trg = 1'b0;
    tick();
    tick();
    total++;
    if (trig !== 8'hDF) begin
      bad++; $display("FAIL rst_expose on got=%h want=DF", trig);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_expose");
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_led = 3'd0;
    cfg_dly = 16'd0; cfg_exp = 16'd0; seq_len = 4'd1; frame_num = 32'd1;
    start = 1'b0; stop = 1'b0; proj_trg = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_zero_timing();
    test_stop();
    test_overrun();
    test_busy_cfg_and_rst();
    test_rst_expose();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
